// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported memory between the core fetch port and the core
// data port using the req/gnt/rvalid handshake on every side. A small FIFO of
// owner IDs (0 = fetch, 1 = data) records who issued each accepted request, so
// the in-order memory responses can be steered back to the right requester.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   instr_req_i/addr_i          fetch request
//   instr_gnt_o/rvalid_o/rdata_o fetch grant and response
//   data_req_i/addr_i/we_i/be_i/wdata_i  data request
//   data_gnt_o/rvalid_o/rdata_o/err_o    data grant and response
//   mem_req_o/addr_o/we_o/be_o/wdata_o   request towards memory
//   mem_gnt_i/rvalid_i/rdata_i/err_i     memory grant and in-order response
//   protocol_err_o              sticky: response seen with nothing in flight
//
// State | meaning
// IDLE   | no lock; a new owner may be selected this cycle
// LOCK_I | fetch is the owner, held until granted or req drops
// LOCK_D | data is the owner, held until granted or req drops
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_MAX  = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;   // 1: data was the most recent grant
  logic   blk_q, blk_d;         // a grant happened last cycle
  logic   perr_q, perr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;

  logic owner_vld, owner_d, owner_req;
  logic full, empty, head, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = ids_q[rptr_q];

  // Owner selection. A held lock always keeps its owner; a fresh selection is
  // suppressed the cycle after a grant so no port is granted back to back.
  always_comb begin
    owner_vld = 1'b0;
    owner_d   = 1'b0;
    if (rst_n) begin
      case (state_q)
        LOCK_I: owner_vld = 1'b1;
        LOCK_D: begin
          owner_vld = 1'b1;
          owner_d   = 1'b1;
        end
        default: begin
          if (!full && !blk_q) begin
            if (instr_req_i && data_req_i) begin
              owner_vld = 1'b1;
              owner_d   = ~last_d_q;
            end else if (data_req_i) begin
              owner_vld = 1'b1;
              owner_d   = 1'b1;
            end else if (instr_req_i) begin
              owner_vld = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign owner_req   = owner_d ? data_req_i : instr_req_i;
  assign mem_req_o   = owner_vld & owner_req & ~full;
  assign mem_addr_o  = !owner_vld ? '0 : (owner_d ? data_addr_i : instr_addr_i);
  assign mem_we_o    = owner_vld & owner_d & data_we_i;
  assign mem_be_o    = !owner_vld ? 4'h0 : (owner_d ? data_be_i : 4'hF);
  assign mem_wdata_o = (owner_vld && owner_d) ? data_wdata_i : '0;

  assign push        = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = push & ~owner_d;
  assign data_gnt_o  = push & owner_d;

  assign pop            = rst_n & mem_rvalid_i & ~empty;
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign protocol_err_o = rst_n & perr_q;

  always_comb begin
    state_d  = IDLE;
    last_d_d = last_d_q;
    blk_d    = push;
    perr_d   = perr_q | (rst_n & mem_rvalid_i & empty);
    ids_d    = ids_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      last_d_d = owner_d;
    end else if (owner_vld && owner_req) begin
      state_d = owner_d ? LOCK_D : LOCK_I;
    end

    if (push) begin
      ids_d[wptr_q] = owner_d;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      blk_q    <= 1'b0;
      perr_q   <= 1'b0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ids_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      blk_q    <= blk_d;
      perr_q   <= perr_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ids_q    <= ids_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_req_i = 1'b0;
  logic [AW-1:0] instr_addr_i = '0;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = 4'h0;
  logic [DW-1:0] data_wdata_i = '0;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          protocol_err_o;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .protocol_err_o(protocol_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of in-flight owners, lock owner, fairness and
  // back-to-back-grant bookkeeping.
  int q[$];
  int lock = -1;
  bit m_last_d = 1'b0;
  bit m_blk = 1'b0;
  bit m_perr = 1'b0;

  always @(negedge clk) begin
    int owner;
    bit oreq, full, e_mreq, e_push, e_irv, e_drv, stray;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [3:0] e_be;
    bit e_we;
    if (!rst_n) begin
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_igrant", instr_gnt_o, 0);
      chk("rst_dgrant", data_gnt_o, 0);
      chk("rst_irvalid", instr_rvalid_o, 0);
      chk("rst_drvalid", data_rvalid_o, 0);
      chk("rst_derr", data_err_o, 0);
      chk("rst_perr", protocol_err_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_be", mem_be_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      q.delete();
      lock = -1;
      m_last_d = 1'b0;
      m_blk = 1'b0;
      m_perr = 1'b0;
    end else begin
      full = (q.size() == MO);
      owner = -1;
      if (lock >= 0) owner = lock;
      else if (!full && !m_blk) begin
        if (instr_req_i && data_req_i) owner = m_last_d ? 0 : 1;
        else if (data_req_i) owner = 1;
        else if (instr_req_i) owner = 0;
      end
      oreq    = (owner == 0) ? instr_req_i : (owner == 1) ? data_req_i : 1'b0;
      e_mreq  = (owner >= 0) && oreq && !full;
      e_push  = e_mreq && mem_gnt_i;
      e_addr  = (owner == 0) ? instr_addr_i : (owner == 1) ? data_addr_i : '0;
      e_we    = (owner == 1) ? data_we_i : 1'b0;
      e_be    = (owner == 0) ? 4'hF : (owner == 1) ? data_be_i : 4'h0;
      e_wdata = (owner == 1) ? data_wdata_i : '0;
      e_irv   = mem_rvalid_i && q.size() > 0 && q[0] == 0;
      e_drv   = mem_rvalid_i && q.size() > 0 && q[0] == 1;
      stray   = mem_rvalid_i && q.size() == 0;

      chk("mem_req", mem_req_o, e_mreq);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, e_we);
      chk("mem_be", mem_be_o, e_be);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("instr_gnt", instr_gnt_o, e_push && owner == 0);
      chk("data_gnt", data_gnt_o, e_push && owner == 1);
      chk("instr_rvalid", instr_rvalid_o, e_irv);
      chk("data_rvalid", data_rvalid_o, e_drv);
      chk("data_err", data_err_o, e_drv && mem_err_i);
      chk("protocol_err", protocol_err_o, m_perr);
      chk("instr_rdata", instr_rdata_o, mem_rdata_i);
      chk("data_rdata", data_rdata_o, mem_rdata_i);

      if (mem_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (e_push) q.push_back(owner);
      if (stray) m_perr = 1'b1;
      if (e_push) begin
        m_last_d = (owner == 1);
        lock = -1;
      end else if (owner >= 0 && oreq) lock = owner;
      else lock = -1;
      m_blk = e_push;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit ir, input logic [AW-1:0] ia, input bit dr, input logic [AW-1:0] da,
                     input bit g, input bit rv, input logic [DW-1:0] rd, input bit er);
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_addr_i = da;
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
  endtask

  task automatic idle();
    drv(0, '0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();

    // Fetch only, immediate grant, response one cycle later
    rst_n = 1'b1;
    drv(1, 32'h20, 0, '0, 1, 0, '0, 0); #1;
    chk("t1_igrant_20", instr_gnt_o, 1);
    chk("t1_addr_20", mem_addr_o, 32'h20);
    step(); drv(1, 32'h24, 0, '0, 1, 1, 32'hA0, 0); #1;
    chk("t1_no_b2b", mem_req_o, 0);
    chk("t1_rv_A0", instr_rvalid_o, 1);
    chk("t1_rdata_A0", instr_rdata_o, 32'hA0);
    step(); drv(1, 32'h24, 0, '0, 1, 0, '0, 0); #1;
    chk("t1_igrant_24", instr_gnt_o, 1);
    chk("t1_addr_24", mem_addr_o, 32'h24);
    step(); drv(1, 32'h28, 0, '0, 1, 1, 32'hA4, 0); #1;
    chk("t1_rv_A4", instr_rvalid_o, 1);
    step(); drv(1, 32'h28, 0, '0, 1, 0, '0, 0); #1;
    chk("t1_igrant_28", instr_gnt_o, 1);
    step(); drv(0, '0, 0, '0, 0, 1, 32'hA8, 0); #1;
    chk("t1_rv_A8", instr_rvalid_o, 1);
    chk("t1_no_drv", data_rvalid_o, 0);
    step(); idle();

    // Tie right after reset: data first, then alternate
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    drv(1, 32'h100, 1, 32'h200, 1, 0, '0, 0); #1;
    chk("t2_first_dgnt", data_gnt_o, 1);
    chk("t2_first_igrant", instr_gnt_o, 0);
    for (int k = 1; k < 8; k++) begin
      step();
      drv(1, 32'h100, 1, 32'h200, 1, k[0], DW'(k), 0); #1;
      if (k[0]) chk("t2_idle_gap", mem_req_o, 0);
      else begin
        chk("t2_alt_dgnt", data_gnt_o, ((k / 2) % 2) == 0);
        chk("t2_alt_igrant", instr_gnt_o, ((k / 2) % 2) == 1);
      end
    end
    step(); idle();

    // Stalled grant keeps fetch address locked
    step(); drv(1, 32'h40, 0, '0, 0, 0, '0, 0); #1;
    chk("t3_addr_0", mem_addr_o, 32'h40);
    chk("t3_req_0", mem_req_o, 1);
    for (int s = 1; s < 4; s++) begin
      step(); drv(1, 32'h40, 1, 32'h1000, s == 3, 0, '0, 0); #1;
      chk("t3_addr_held", mem_addr_o, 32'h40);
      chk("t3_dgnt_held", data_gnt_o, 0);
      chk("t3_igrant", instr_gnt_o, s == 3);
    end
    step(); drv(0, '0, 1, 32'h1000, 1, 1, 32'hB0, 0); #1;
    chk("t3_irv", instr_rvalid_o, 1);
    step(); drv(0, '0, 1, 32'h1000, 1, 0, '0, 0); #1;
    chk("t3_dgnt", data_gnt_o, 1);
    chk("t3_addr_1000", mem_addr_o, 32'h1000);
    step(); drv(0, '0, 0, '0, 0, 1, 32'hB4, 0); #1;
    chk("t3_drv", data_rvalid_o, 1);
    chk("t3_drdata", data_rdata_o, 32'hB4);
    step(); idle();

    // Full FIFO, delayed responses, error on the data response
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    drv(1, 32'h300, 0, '0, 1, 0, '0, 0); #1;
    chk("t4_igrant", instr_gnt_o, 1);
    data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'hDEAD;
    step(); drv(0, '0, 1, 32'h2000, 1, 0, '0, 0); #1;
    chk("t4_gap", mem_req_o, 0);
    step(); drv(0, '0, 1, 32'h2000, 1, 0, '0, 0); #1;
    chk("t4_dgnt", data_gnt_o, 1);
    chk("t4_we", mem_we_o, 1);
    chk("t4_be", mem_be_o, 4'h3);
    for (int f = 0; f < 2; f++) begin
      step(); drv(0, '0, 1, 32'h2000, 1, 0, '0, 0); #1;
      chk("t4_full_noreq", mem_req_o, 0);
      chk("t4_full_nodgnt", data_gnt_o, 0);
    end
    data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = '0;
    step(); drv(0, '0, 0, '0, 0, 1, 32'hC0, 0); #1;
    chk("t4_irv", instr_rvalid_o, 1);
    chk("t4_no_drv", data_rvalid_o, 0);
    step(); idle();
    step(); drv(0, '0, 0, '0, 0, 1, 32'hC4, 1); #1;
    chk("t4_drv", data_rvalid_o, 1);
    chk("t4_derr", data_err_o, 1);
    step(); idle(); #1;
    chk("t4_derr_once", data_err_o, 0);

    // Stray response with empty FIFO
    step(); drv(0, '0, 0, '0, 0, 1, 32'hE0, 0); #1;
    chk("t5_no_irv", instr_rvalid_o, 0);
    chk("t5_no_drv", data_rvalid_o, 0);
    chk("t5_perr_pre", protocol_err_o, 0);
    step(); idle(); #1;
    chk("t5_perr_set", protocol_err_o, 1);
    step(); step();
    chk("t5_perr_sticky", protocol_err_o, 1);
    step(); rst_n = 1'b0;
    drv(1, 32'h44, 1, 32'h48, 1, 1, 32'hE4, 1); #1;
    chk("t5_rst_req", mem_req_o, 0);
    chk("t5_rst_igrant", instr_gnt_o, 0);
    chk("t5_rst_dgnt", data_gnt_o, 0);
    chk("t5_rst_perr", protocol_err_o, 0);
    chk("t5_rst_addr", mem_addr_o, 0);
    step(); rst_n = 1'b1; idle(); #1;
    chk("t5_perr_clr", protocol_err_o, 0);

    // Reset with two transactions outstanding
    step(); drv(1, 32'h500, 0, '0, 1, 0, '0, 0); #1;
    chk("t6_igrant", instr_gnt_o, 1);
    step(); drv(0, '0, 1, 32'h3000, 1, 0, '0, 0);
    step(); drv(0, '0, 1, 32'h3000, 1, 0, '0, 0); #1;
    chk("t6_dgnt", data_gnt_o, 1);
    step(); rst_n = 1'b0; idle();
    step(); rst_n = 1'b1;
    drv(1, 32'h504, 0, '0, 0, 1, 32'hF0, 0); #1;
    chk("t6_no_irv", instr_rvalid_o, 0);
    chk("t6_not_full", mem_req_o, 1);
    step(); idle(); #1;
    chk("t6_perr", protocol_err_o, 1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
